// File: rtl/ff_fmt_array.sv
// ff_fmt_array: multi-channel force-format output engine.
// Pin vectors are queued in a FIFO. On each enabled edge one vector is popped.
// A per-channel 3-bit format code turns the vector into registered ODDR D1/D2
// data and an output enable. Formats are written to a shadow set and copied
// to the active set as a whole, so all channels change format on the same
// update.
module ff_fmt_array #(
  parameter  int N_CH  = 8,
  parameter  int DEPTH = 16,
  parameter  int CNT_W = 32,
  localparam int AW    = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [N_CH-1:0]   S_DATA,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic              EN,
  input  logic              CFG_WE,
  input  logic [AW-1:0]     CFG_ADDR,
  input  logic [2:0]        CFG_FMT,
  input  logic              CFG_APPLY,
  input  logic              CLR_ERR,
  output logic [N_CH-1:0]   D1,
  output logic [N_CH-1:0]   D2,
  output logic [N_CH-1:0]   OE,
  output logic              UNDERRUN,
  output logic [LW-1:0]     LEVEL,
  output logic [CNT_W-1:0]  VEC_CNT
);

  typedef enum logic [2:0] {
    FMT_FORCE0 = 3'd0,
    FMT_FORCE1 = 3'd1,
    FMT_NRZ    = 3'd2,
    FMT_RZ     = 3'd3,
    FMT_R1     = 3'd4,
    FMT_NRZI   = 3'd5,
    FMT_HOLD   = 3'd6,
    FMT_HIZ    = 3'd7
  } fmt_e;

  localparam int          PW     = $clog2(DEPTH);
  localparam int unsigned NCH_U  = N_CH;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [AW:0]   NCH_L = (AW + 1)'(N_CH);

  logic [N_CH-1:0]  mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic             rdy;
  logic             push;
  logic             pop;
  logic             empty;
  logic [N_CH-1:0]  vec;
  logic             addr_ok;

  fmt_e             shadow [N_CH];
  fmt_e             active [N_CH];

  logic [N_CH-1:0]  d1_q, d2_q, oe_q;
  logic [N_CH-1:0]  d1_n, d2_n, oe_n;
  logic             under_q;
  logic [CNT_W-1:0] cnt_q;

  assign empty   = (level == '0);
  assign S_READY = rdy && (level != FULL);
  assign push    = S_VALID && S_READY;
  assign pop     = EN && !empty;
  // Underrun issues an all-zero idle vector; no bypass of a same-edge push.
  assign vec     = empty ? '0 : mem[rd_ptr];
  assign addr_ok = ({1'b0, CFG_ADDR} < NCH_L);

  assign D1       = d1_q;
  assign D2       = d2_q;
  assign OE       = oe_q;
  assign UNDERRUN = under_q;
  assign LEVEL    = level;
  assign VEC_CNT  = cnt_q;

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= S_DATA;
  end

  // FIFO pointers, occupancy and the post-reset ready flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rdy    <= 1'b0;
    end else begin
      rdy <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Shadow writes and whole-set apply; apply copies the pre-write shadow
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < NCH_U; i++) begin
        shadow[i] <= FMT_FORCE0;
        active[i] <= FMT_FORCE0;
      end
    end else begin
      if (CFG_APPLY) begin
        for (int unsigned i = 0; i < NCH_U; i++) active[i] <= shadow[i];
      end
      if (CFG_WE && addr_ok) shadow[CFG_ADDR] <= fmt_e'(CFG_FMT);
    end
  end

  // Per-channel format decode of the issued vector against the active set
  always_comb begin
    d1_n = d1_q;
    d2_n = d2_q;
    oe_n = oe_q;
    for (int unsigned i = 0; i < NCH_U; i++) begin
      case (active[i])
        FMT_FORCE0: begin d1_n[i] = 1'b0;    d2_n[i] = 1'b0;    oe_n[i] = 1'b1; end
        FMT_FORCE1: begin d1_n[i] = 1'b1;    d2_n[i] = 1'b1;    oe_n[i] = 1'b1; end
        FMT_NRZ:    begin d1_n[i] = vec[i];  d2_n[i] = vec[i];  oe_n[i] = 1'b1; end
        FMT_RZ:     begin d1_n[i] = vec[i];  d2_n[i] = 1'b0;    oe_n[i] = 1'b1; end
        FMT_R1:     begin d1_n[i] = vec[i];  d2_n[i] = 1'b1;    oe_n[i] = 1'b1; end
        FMT_NRZI:   begin d1_n[i] = ~vec[i]; d2_n[i] = ~vec[i]; oe_n[i] = 1'b1; end
        FMT_HOLD:   begin d1_n[i] = d1_q[i]; d2_n[i] = d2_q[i]; oe_n[i] = oe_q[i]; end
        FMT_HIZ:    begin d1_n[i] = 1'b0;    d2_n[i] = 1'b0;    oe_n[i] = 1'b0; end
      endcase
    end
  end

  // Registered outputs, issue counter and sticky underrun (set beats clear)
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      d1_q    <= '0;
      d2_q    <= '0;
      oe_q    <= '0;
      under_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (EN) begin
        d1_q <= d1_n;
        d2_q <= d2_n;
        oe_q <= oe_n;
        if (!empty) cnt_q <= cnt_q + CNT_W'(1);
      end
      if (EN && empty)  under_q <= 1'b1;
      else if (CLR_ERR) under_q <= 1'b0;
    end
  end

endmodule
